// File: rtl/cache_pkg.sv
// Shared geometry and FSM encoding for the 2-way write-back cache.
package cache_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int INDEX_W  = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W;
  localparam int NUM_SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    DONE
  } state_t;
endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/dirty/tag/data per set.
// Ports:
//   clock, resetn            clock, async active-low reset (clears valid/dirty)
//   i_idx                    set index for both the read and the write port
//   o_valid/o_dirty/o_tag/o_data  combinational read of set i_idx
//   i_we, i_dirty, i_tag, i_data  write of set i_idx; a write always marks the line valid
module cache_way_array
  import cache_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic               i_we,
  input  logic               i_dirty,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [DATA_W-1:0]  i_data,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_data
);
  logic [NUM_SETS-1:0]             r_valid;
  logic [NUM_SETS-1:0]             r_dirty;
  logic [NUM_SETS-1:0][TAG_W-1:0]  r_tag;
  logic [NUM_SETS-1:0][DATA_W-1:0] r_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_dirty;
      r_tag[i_idx]   <= i_tag;
      r_data[i_idx]  <= i_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
endmodule

// File: rtl/cache_2way_wb.sv
// 2-way set-associative, write-back, write-allocate cache with a req/ack
// backing-memory port. One access at a time; req is only sampled in IDLE.
// Ports:
//   clock, resetn                  clock, async active-low reset
//   req, wren, address, data       access request (captured in IDLE)
//   q, busy, done, hit, miss       access result / status
//   dirty1, dirty2                 dirty bits of way 0/1 of the last set touched
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack  backing memory
module cache_2way_wb
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              miss,
  output logic              dirty1,
  output logic              dirty2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  state_t              r_state;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_SETS-1:0] r_lru;     // per set: index of the least recently used way
  logic                r_victim;

  logic [INDEX_W-1:0]       w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic [1:0]               w_vld, w_drt, w_hitv, w_we;
  logic [1:0][TAG_W-1:0]    w_rtag;
  logic [1:0][DATA_W-1:0]   w_rdata;
  logic                     w_hit, w_hway, w_victim, w_wdirty;
  logic [DATA_W-1:0]        w_wdata;

  assign w_idx = r_addr[INDEX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:INDEX_W];

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way_array u_way (
      .clock   (clock),
      .resetn  (resetn),
      .i_idx   (w_idx),
      .i_we    (w_we[g]),
      .i_dirty (w_wdirty),
      .i_tag   (w_tag),
      .i_data  (w_wdata),
      .o_valid (w_vld[g]),
      .o_dirty (w_drt[g]),
      .o_tag   (w_rtag[g]),
      .o_data  (w_rdata[g])
    );
    assign w_hitv[g] = w_vld[g] && (w_rtag[g] == w_tag);
  end

  assign w_hit  = |w_hitv;
  assign w_hway = w_hitv[1];
  // Prefer an empty way (way 0 first); only fall back to LRU when the set is full.
  assign w_victim = !w_vld[0] ? 1'b0 : (!w_vld[1] ? 1'b1 : r_lru[w_idx]);

  // Single write port per way: write hit in LOOKUP, line allocate on fill ack.
  always_comb begin
    w_we     = '0;
    w_wdirty = 1'b0;
    w_wdata  = r_data;
    if (r_state == LOOKUP && w_hit && r_wren) begin
      w_we[w_hway] = 1'b1;
      w_wdirty     = 1'b1;
    end else if (r_state == FILL && mem_ack) begin
      w_we[r_victim] = 1'b1;
      w_wdirty       = r_wren;
      w_wdata        = r_wren ? r_data : mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_lru     <= '0;
      r_victim  <= 1'b0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      dirty1    <= 1'b0;
      dirty2    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (req) begin
          r_wren  <= wren;
          r_addr  <= address;
          r_data  <= data;
          hit     <= 1'b0;
          miss    <= 1'b0;
          busy    <= 1'b1;
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          hit          <= 1'b1;
          q            <= r_wren ? r_data : w_rdata[w_hway];
          r_lru[w_idx] <= ~w_hway;
          r_state      <= DONE;
        end else begin
          miss     <= 1'b1;
          r_victim <= w_victim;
          mem_req  <= 1'b1;
          if (w_vld[w_victim] && w_drt[w_victim]) begin
            mem_we    <= 1'b1;
            mem_addr  <= {w_rtag[w_victim], w_idx};
            mem_wdata <= w_rdata[w_victim];
            r_state   <= WB;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= r_addr;
            r_state  <= FILL;
          end
        end
        // mem_req stays high across the WB->FILL hand-over; address/we switch on the ack.
        WB: if (mem_ack) begin
          mem_we   <= 1'b0;
          mem_addr <= r_addr;
          r_state  <= FILL;
        end
        FILL: if (mem_ack) begin
          mem_req         <= 1'b0;
          q               <= r_wren ? r_data : mem_rdata;
          r_lru[w_idx]    <= ~r_victim;
          r_state         <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          dirty1  <= w_drt[0];
          dirty2  <= w_drt[1];
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_2way_wb.sv
module tb_cache_2way_wb;
  typedef struct packed {
    logic [7:0]  q;
    logic        hit;
    logic        miss;
    logic        d1;
    logic        d2;
    logic [31:0] lat;
  } res_t;
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } mop_t;

  logic       clock = 1'b0;
  logic       resetn, req, wren;
  logic [4:0] address;
  logic [7:0] data, q, mem_wdata, mem_rdata;
  logic       busy, done, hit, miss, dirty1, dirty2, mem_req, mem_we;
  logic [4:0] mem_addr;
  logic       m_ack, f_ack;
  wire        mem_ack = m_ack | f_ack;

  cache_2way_wb dut (
    .clock(clock), .resetn(resetn), .req(req), .wren(wren), .address(address),
    .data(data), .q(q), .busy(busy), .done(done), .hit(hit), .miss(miss),
    .dirty1(dirty1), .dirty2(dirty2), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int t_req = 0;
  int mem_dly = 2;
  int checks = 0;
  int errors = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  mop_t exp_m[$];
  mop_t obs_m[$];

  // Behavioural 32x8 backing memory, ack mem_dly cycles after req is first seen.
  logic [7:0] mem [32];
  bit         minit;
  int         mcnt;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    m_ack <= 1'b0;
    if (!minit) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 11 + 1);
      mem[5] <= 8'h3C;
      minit  <= 1'b1;
      mcnt   <= 0;
    end else if (mem_req && !m_ack) begin
      if (mcnt >= mem_dly) begin
        m_ack     <= 1'b1;
        mcnt      <= 0;
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end else mcnt <= mcnt + 1;
    end else if (!mem_req) mcnt <= 0;
  end

  // Output monitor: collects completed accesses and memory transactions.
  always @(negedge clock) begin
    if (resetn && done)
      obs_q.push_back({q, hit, miss, dirty1, dirty2, 32'(cyc - t_req)});
    if (mem_req && m_ack)
      obs_m.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // nph: memory phases expected (0 hit, 1 fill, 2 writeback+fill).
  task automatic access(input logic w, input logic [4:0] a, input logic [7:0] d, input int nph,
                        input logic [7:0] eq, input logic ed1, input logic ed2,
                        input logic [4:0] wba, input logic [7:0] wbd, input bit mid);
    res_t e, o;
    mop_t em, om;
    bit   got, pulsed;
    e = {eq, nph == 0, nph != 0, ed1, ed2, 32'(3 + nph * (mem_dly + 2))};
    exp_q.push_back(e);
    if (nph == 2) exp_m.push_back({1'b1, wba, wbd});
    if (nph >= 1) exp_m.push_back({1'b0, a, 8'h00});
    @(posedge clock); #1;
    req = 1'b1; wren = w; address = a; data = d; t_req = cyc;
    @(posedge clock); #1;
    req = 1'b0; wren = 1'b0; address = '0; data = '0;
    got = 0; pulsed = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clock); #1;
      if (obs_q.size() != 0) got = 1;
      else if (mid && !pulsed && mem_req && !mem_we) begin
        pulsed = 1;
        req = 1'b1; wren = 1'b1; address = 5'h1F; data = 8'hEE;
        @(posedge clock); #1;
        req = 1'b0; wren = 1'b0; address = '0; data = '0;
      end
    end
    chk("done_seen", 32'(got), 1);
    if (got) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("q", 32'(o.q), 32'(e.q));
      chk("hit", 32'(o.hit), 32'(e.hit));
      chk("miss", 32'(o.miss), 32'(e.miss));
      chk("dirty1", 32'(o.d1), 32'(e.d1));
      chk("dirty2", 32'(o.d2), 32'(e.d2));
      chk("latency", o.lat, e.lat);
    end
    chk("mem_op_count", 32'(obs_m.size()), 32'(exp_m.size()));
    while (exp_m.size() != 0 && obs_m.size() != 0) begin
      em = exp_m.pop_front();
      om = obs_m.pop_front();
      chk("mem_op", 32'(om), 32'(em));
    end
    exp_m.delete(); obs_m.delete();
    repeat (3) @(posedge clock);
    #1 chk("extra_done", 32'(obs_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    resetn = 1'b0; req = 1'b0; wren = 1'b0; address = '0; data = '0; f_ack = 1'b0;
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", 32'({hit, miss, dirty1, dirty2}), 0);
    chk("rst_mem", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    mem_dly = 2;
    access(1'b0, 5'h05, 8'h00, 1, 8'h3C, 1'b0, 1'b0, 5'h00, 8'h00, 0); // cold read
    access(1'b1, 5'h05, 8'hA7, 0, 8'hA7, 1'b1, 1'b0, 5'h00, 8'h00, 0); // write hit
    access(1'b0, 5'h09, 8'h00, 1, 8'h64, 1'b1, 1'b0, 5'h00, 8'h00, 0); // fill empty way 1
    access(1'b0, 5'h0D, 8'h00, 2, 8'h90, 1'b0, 1'b0, 5'h05, 8'hA7, 0); // evict dirty LRU way 0
    mem_dly = 0;
    access(1'b1, 5'h12, 8'h55, 1, 8'h55, 1'b1, 1'b0, 5'h00, 8'h00, 0); // write-miss allocate
    access(1'b0, 5'h12, 8'h00, 0, 8'h55, 1'b1, 1'b0, 5'h00, 8'h00, 0); // read hit on it
    mem_dly = 4;
    access(1'b0, 5'h05, 8'h00, 1, 8'hA7, 1'b0, 1'b0, 5'h00, 8'h00, 1); // req pulsed mid-fill

    // Stray mem_ack while idle must not start anything.
    @(negedge clock) f_ack = 1'b1;
    @(negedge clock) f_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_ack_busy", 32'(busy), 0);
    chk("idle_ack_req", 32'(mem_req), 0);
    chk("idle_ack_done", 32'(obs_q.size()), 0);

    mem_dly = 1;
    access(1'b1, 5'h03, 8'h11, 1, 8'h11, 1'b1, 1'b0, 5'h00, 8'h00, 0);
    access(1'b1, 5'h07, 8'h22, 1, 8'h22, 1'b1, 1'b1, 5'h00, 8'h00, 0);

    // Reset while the writeback of 0x03 is outstanding.
    mem_dly = 10;
    @(posedge clock); #1;
    req = 1'b1; wren = 1'b0; address = 5'h0B;
    @(posedge clock); #1;
    req = 1'b0; address = '0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (mem_req && mem_we) seen = 1;
    end
    chk("wb_seen", 32'(seen), 1);
    chk("wb_addr", 32'(mem_addr), 32'h03);
    chk("wb_data", 32'(mem_wdata), 32'h11);
    resetn = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_q", 32'(q), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    obs_m.delete();
    mem_dly = 1;
    access(1'b0, 5'h05, 8'h00, 1, 8'hA7, 1'b0, 1'b0, 5'h00, 8'h00, 0); // invalidated by reset

    chk("sb_empty", 32'(exp_q.size() + obs_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_2way_wb.md
Name: cache_2way_wb

Overview:
- 2-way set-associative, write-back, write-allocate cache: 5-bit address, 8-bit data.
- Sits directly upstream of the board display top-level.
  - Display shows q, address and input data on the HEX digits.
  - Display shows hit, miss, dirty1 and dirty2 on LEDG[3:0].
- Misses and evictions go to a backing memory through a req/ack handshake port.

Parameters:
- ADDR_W, 5, byte address width; tag width = ADDR_W - INDEX_W.
- DATA_W, 8, data word width.
- INDEX_W, 2, set index width. Set index = address[INDEX_W-1:0]; 4 sets by default.

Ports:
clock      in   1        system clock, rising edge
resetn     in   1        asynchronous active-low reset
req        in   1        start access; sampled in IDLE only
wren       in   1        1 = write, 0 = read; captured with req
address    in   ADDR_W   access address; captured with req
data       in   DATA_W   write data; captured with req
q          out  DATA_W   read result, or written value on a write
busy       out  1        access in progress
done       out  1        1-cycle pulse when the access completes
hit        out  1        last access hit; held until the next req is accepted
miss       out  1        last access missed; held until the next req is accepted
dirty1     out  1        dirty bit of way 0, set of last access, post-access
dirty2     out  1        dirty bit of way 1, set of last access, post-access
mem_req    out  1        memory request; held until mem_ack
mem_we     out  1        1 = writeback, 0 = fill read
mem_addr   out  ADDR_W   memory address
mem_wdata  out  DATA_W   writeback data
mem_rdata  in   DATA_W   fill data; valid in the mem_ack cycle
mem_ack    in   1        memory completion, 1 cycle

Behaviour:
- Reset (async, resetn=0):
  - All valid, dirty and LRU bits cleared; state = IDLE.
  - All outputs 0, including q and mem_*.
  - Reset mid-access aborts it. An in-flight mem_req drops immediately. Dirty data is lost (accepted).
- State storage, per set and way: valid, dirty, tag, data. One LRU bit per set, naming the least recently used way.
- FSM: IDLE -> LOOKUP -> {DONE | WB | FILL}; WB -> FILL; FILL -> DONE; DONE -> IDLE.
- IDLE:
  - On req=1: capture wren/address/data, clear hit and miss, go to LOOKUP.
  - busy=1 from the next cycle through DONE inclusive.
- LOOKUP (exactly 1 cycle): compare the captured tag against both valid ways of the set.
  - Hit, read: q <= way data.
  - Hit, write: way data <= captured data, dirty <= 1, q <= captured data.
  - Hit, either kind: hit <= 1, LRU <= other way, go to DONE.
  - Miss: miss <= 1. Victim = first invalid way (way 0 before way 1), else the LRU way.
  - Miss with victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - Hold all four stable until mem_ack, then go to FILL.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr=captured address; hold until mem_ack.
  - In the mem_ack cycle: victim valid <= 1, victim tag <= captured tag, LRU <= other way.
  - Read: victim data <= mem_rdata, dirty <= 0, q <= mem_rdata.
  - Write: victim data <= captured data, dirty <= 1, q <= captured data.
  - Then go to DONE.
- DONE: done=1 for one cycle; dirty1/dirty2 updated from the set of the captured index; go to IDLE.
- Latency, req to done:
  - Hit: 3 cycles.
  - Clean miss: 3 cycles + fill wait.
  - Dirty miss: adds the writeback wait.
- mem_req deasserts the cycle after mem_ack. With zero-wait memory (ack the cycle after req) each phase costs 2 cycles.
- Boundary cases:
  - req while busy: ignored, no queueing.
  - mem_ack outside WB/FILL: ignored.
  - req held high across DONE: a new access starts from IDLE on the following cycle.
  - Same-set back-to-back accesses: see updated LRU and dirty state.
- Widths: tag = address[ADDR_W-1:INDEX_W]. No arithmetic besides the comparators.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, INDEX_W and derived TAG_W / NUM_SETS.
  - State encoding: IDLE, LOOKUP, WB, FILL, DONE.
- One natural sub-module, cache_way_array: per-way valid/dirty/tag/data storage with a combinational read port and a single write port. Instantiated twice.
- LRU bits and the FSM live in the top module.
- The bench supplies a behavioural 32x8 memory model with a configurable ack delay.

Test Plan:
- Cold read: reset, read 0x05 with mem 0x05=0x3C, ack delay 2 -> miss=1, FILL mem_addr=0x05, q=0x3C, done, dirty1=dirty2=0.
- Write hit: after the above, write 0x05=0xA7 -> hit=1, no mem_req, done 3 cycles after req, q=0xA7, dirty1=1.
- Conflict fill: read 0x09 (set 1, way 1 empty) -> miss, no WB. Then read 0x0D, which evicts LRU way 0 (dirty 0xA7) -> WB mem_addr=0x05, mem_wdata=0xA7, then FILL 0x0D.
- Write miss allocate: write 0x12=0x55 to an empty set -> FILL read issued, line = 0x55, dirty=1. A later read 0x12 hits with q=0x55.
- req pulsed during FILL, and mem_ack pulsed in IDLE -> both ignored; exactly one done per accepted req.
- resetn low while in WB -> mem_req=0 immediately. After release, read 0x05 misses (cache invalidated).
